// File: rtl/jtopl_slot_wr.sv
// Operator-slot write sequencer: captures a CPU register write and replays it
// in step with the rotating operator slot counter, pulsing alignment strobes
// as the target slot passes through the pipeline.
module jtopl_slot_wr #(
    parameter int unsigned SLOTS = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       wr,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       update_op_I,
    output logic       update_op_II,
    output logic       update_op_IV,
    output logic [4:0] slot,
    output logic       zero,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [2:0] {StIdle, StWait, StS1, StS2, StS3} state_t;

    localparam logic [4:0] SlotLast = 5'(SLOTS - 1);

    logic [4:0] slot_q, slot_d;
    state_t     state_q, state_d;
    logic [7:0] sel_q, sel_d;
    logic [7:0] dout_q, dout_d;
    logic [4:0] target_q, target_d;
    logic [2:0] group_q, group_d;
    logic       overrun_q, overrun_d;

    logic       sel_wr, data_wr;
    logic       grp_ok, off_ok, hit;
    logic [1:0] off_hi;
    logic [2:0] off_lo;
    logic [4:0] sel_target;

    assign sel_wr  = wr & ~addr;
    assign data_wr = wr & addr;
    assign hit     = (slot_q == target_q);

    // Decode the selection register into a group validity flag and a target slot.
    always_comb begin
        off_hi = sel_q[4:3];
        off_lo = sel_q[2:0];
        grp_ok = 1'b0;
        case (sel_q[7:5])
            3'd1, 3'd2, 3'd3, 3'd4, 3'd7: grp_ok = 1'b1;
            default:                      grp_ok = 1'b0;
        endcase
        off_ok = (off_hi != 2'd3) && (off_lo <= 3'd5);
        // Offset banks are 8 apart in the register map but only 6 slots apart.
        sel_target = ({3'd0, off_hi} << 2) + ({3'd0, off_hi} << 1) + {2'd0, off_lo};
    end

    // Next-state logic: slot rotation, register capture and write sequencing.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        sel_d     = sel_q;
        dout_d    = dout_q;
        target_d  = target_q;
        group_d   = group_q;
        overrun_d = overrun_q;
        if (cen) begin
            slot_d = (slot_q == SlotLast) ? 5'd0 : slot_q + 5'd1;
            if (sel_wr) begin
                sel_d = din;
            end
            case (state_q)
                StIdle: begin
                    if (data_wr && grp_ok && off_ok) begin
                        state_d  = StWait;
                        dout_d   = din;
                        target_d = sel_target;
                        group_d  = sel_q[7:5];
                    end
                end
                StWait:  if (hit) state_d = StS1;
                StS1:    state_d = StS2;
                StS2:    state_d = StS3;
                StS3:    state_d = StIdle;
                default: state_d = StIdle;
            endcase
            // A second data write cannot be queued; flag it and keep the first.
            if (data_wr && (state_q != StIdle)) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q    <= 5'd0;
            state_q   <= StIdle;
            sel_q     <= 8'd0;
            dout_q    <= 8'd0;
            target_q  <= 5'd0;
            group_q   <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            state_q   <= state_d;
            sel_q     <= sel_d;
            dout_q    <= dout_d;
            target_q  <= target_d;
            group_q   <= group_d;
            overrun_q <= overrun_d;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        busy         = (state_q != StIdle);
        update_op_I  = (state_q == StWait) && hit;
        update_op_II = (state_q == StS1);
        update_op_IV = (state_q == StS3);
        up_mult      = busy && (group_q == 3'd1);
        up_ksl_tl    = busy && (group_q == 3'd2);
        up_ar_dr     = busy && (group_q == 3'd3);
        up_sl_rr     = busy && (group_q == 3'd4);
        up_wav       = busy && (group_q == 3'd7);
        zero         = (slot_q == 5'd0);
        slot         = slot_q;
        dout         = dout_q;
        overrun      = overrun_q;
    end

endmodule

// File: tb/tb_jtopl_slot_wr.sv
// Self-checking bench for jtopl_slot_wr: directed scenarios plus randomized
// traffic compared against an event-count model of the write sequencer.
module tb_jtopl_slot_wr;

    localparam int SLOTS = 18;

    logic       clk = 1'b0;
    logic       rst_n, cen, wr, addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav;
    logic       update_op_I, update_op_II, update_op_IV;
    logic [4:0] slot;
    logic       zero, busy, overrun;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a pending write is "m_j edges until alignment" counted
    // from the accepting edge; strobes follow at fixed offsets from there.
    int         m_slot;
    logic [7:0] m_sel;
    logic [7:0] m_dout;
    int         m_grp;
    bit         m_pend;
    int         m_pos;
    int         m_j;
    bit         m_ovr;

    jtopl_slot_wr #(.SLOTS(SLOTS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cen          (cen),
        .wr           (wr),
        .addr         (addr),
        .din          (din),
        .dout         (dout),
        .up_mult      (up_mult),
        .up_ksl_tl    (up_ksl_tl),
        .up_ar_dr     (up_ar_dr),
        .up_sl_rr     (up_sl_rr),
        .up_wav       (up_wav),
        .update_op_I  (update_op_I),
        .update_op_II (update_op_II),
        .update_op_IV (update_op_IV),
        .slot         (slot),
        .zero         (zero),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic bit sel_valid(input logic [7:0] s);
        int g  = int'(s[7:5]);
        int hi = int'(s[4:3]);
        int lo = int'(s[2:0]);
        return (g inside {1, 2, 3, 4, 7}) && (hi < 3) && (lo < 6);
    endfunction

    function automatic void mdl_edge(input logic r, c, w, a, input logic [7:0] d);
        bit took = 0;
        if (!r) begin
            m_slot = 0; m_sel = 8'h00; m_dout = 8'h00; m_grp = 0;
            m_pend = 0; m_pos = 0; m_j = 0; m_ovr = 0;
            return;
        end
        if (!c) return;
        if (w && !a) m_sel = d;
        if (w && a) begin
            if (m_pend) begin
                m_ovr = 1;
            end else if (sel_valid(m_sel)) begin
                int tgt = int'(m_sel[4:3]) * 6 + int'(m_sel[2:0]);
                m_dout = d;
                m_grp  = int'(m_sel[7:5]);
                m_j    = (tgt - m_slot - 1 + SLOTS) % SLOTS;
                m_pos  = 0;
                m_pend = 1;
                took   = 1;
            end
        end
        if (m_pend && !took) begin
            m_pos++;
            if (m_pos == m_j + 4) m_pend = 0;
        end
        m_slot = (m_slot + 1) % SLOTS;
    endfunction

    function automatic logic [23:0] obs();
        return {dout, slot, zero, busy, overrun, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr,
                up_wav, update_op_I, update_op_II, update_op_IV};
    endfunction

    function automatic logic [23:0] expv();
        return {m_dout, 5'(m_slot), m_slot == 0, m_pend, m_ovr,
                m_pend && m_grp == 1, m_pend && m_grp == 2, m_pend && m_grp == 3,
                m_pend && m_grp == 4, m_pend && m_grp == 7,
                m_pend && m_pos == m_j, m_pend && m_pos == m_j + 1,
                m_pend && m_pos == m_j + 3};
    endfunction

    task automatic cyc(input logic r, c, w, a, input logic [7:0] d);
        rst_n = r; cen = c; wr = w; addr = a; din = d;
        @(posedge clk);
        mdl_edge(r, c, w, a, d);
        #1;
    endtask

    // Idle cycles until the pending write retires, recording strobe slots.
    task automatic watch(output int s1, s2, s4, sb, output logic z2, output int bad);
        s1 = -1; s2 = -1; s4 = -1; sb = -1; z2 = 1'b0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0, 0, 8'h00);
            if (obs() !== expv()) bad++;
            if (update_op_I)  s1 = int'(slot);
            if (update_op_II) begin s2 = int'(slot); z2 = zero; end
            if (update_op_IV) s4 = int'(slot);
            if (!busy) begin sb = int'(slot); break; end
        end
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 1, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL reset_vec: got %h expected %h", obs(), expv());
            end
            n_chk++;
            if ({zero, busy, update_op_I, update_op_II, update_op_IV, slot} !== 10'b10_000_00000) begin
                n_fail++;
                $display("FAIL reset_flags: got zero=%b busy=%b slot=%0d expected zero=1 busy=0 slot=0",
                         zero, busy, slot);
            end
            cyc(0, i[0], 0, 0, 8'h00);
        end
    endtask

    task automatic test_mult();
        int s1, s2, s4, sb, bad;
        logic z2;
        cyc(0, 1, 0, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h20);
        for (int i = 0; i < 20 && m_slot != 0; i++) cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 1, 1, 1, 8'hA5);
        n_chk++;
        if ({dout, up_mult, busy} !== {8'hA5, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL mult_accept: got dout=%h up_mult=%b busy=%b expected a5 1 1",
                     dout, up_mult, busy);
        end
        watch(s1, s2, s4, sb, z2, bad);
        n_chk++;
        if ({s1, s2, s4, sb} !== {32'sd0, 32'sd1, 32'sd3, 32'sd4}) begin
            n_fail++;
            $display("FAIL mult_slots: got I=%0d II=%0d IV=%0d idle=%0d expected 0 1 3 4",
                     s1, s2, s4, sb);
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL mult_model: got %0d differing cycles expected 0", bad);
        end
    endtask

    task automatic test_wrap();
        int s1, s2, s4, sb, bad;
        logic z2;
        cyc(0, 1, 0, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h55);
        cyc(1, 1, 1, 1, 8'h3F);
        n_chk++;
        if ({dout, up_ksl_tl, up_mult} !== {8'h3F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_accept: got dout=%h ksl_tl=%b mult=%b expected 3f 1 0",
                     dout, up_ksl_tl, up_mult);
        end
        watch(s1, s2, s4, sb, z2, bad);
        n_chk++;
        if ({s1, s2, s4} !== {32'sd17, 32'sd0, 32'sd2}) begin
            n_fail++;
            $display("FAIL wrap_slots: got I=%0d II=%0d IV=%0d expected 17 0 2", s1, s2, s4);
        end
        n_chk++;
        if (z2 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_zero: got zero=%b during S1 expected 1", z2);
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL wrap_model: got %0d differing cycles expected 0", bad);
        end
    endtask

    task automatic test_invalid();
        int s1, s2, s4, sb, bad;
        logic z2;
        logic [7:0] sels [2];
        sels[0] = 8'h26;
        sels[1] = 8'hA0;
        cyc(0, 1, 0, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h21);
        cyc(1, 1, 1, 1, 8'h6C);
        watch(s1, s2, s4, sb, z2, bad);
        for (int k = 0; k < 2; k++) begin
            cyc(1, 1, 1, 0, sels[k]);
            cyc(1, 1, 1, 1, 8'h11);
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if ({dout, busy, overrun, update_op_I, update_op_II, update_op_IV,
                     up_mult, up_wav} !== {8'h6C, 7'b0}) begin
                    n_fail++;
                    $display("FAIL invalid_%h: got dout=%h busy=%b ovr=%b strobes=%b expected 6c 0 0 0",
                             sels[k], dout, busy, overrun,
                             {update_op_I, update_op_II, update_op_IV, up_mult, up_wav});
                end
                cyc(1, 1, 0, 0, 8'h00);
            end
        end
    endtask

    task automatic test_overrun();
        int s1, s2, s4, sb, bad;
        logic z2;
        cyc(0, 1, 0, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h68);
        cyc(1, 1, 1, 1, 8'h5A);
        cyc(1, 1, 1, 1, 8'hC3);
        n_chk++;
        if ({overrun, dout, up_ar_dr} !== {1'b1, 8'h5A, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun_set: got ovr=%b dout=%h ar_dr=%b expected 1 5a 1",
                     overrun, dout, up_ar_dr);
        end
        cyc(1, 1, 1, 0, 8'hE2);
        watch(s1, s2, s4, sb, z2, bad);
        n_chk++;
        if ({s1, s4, sb} !== {32'sd6, 32'sd9, 32'sd10}) begin
            n_fail++;
            $display("FAIL overrun_slots: got I=%0d IV=%0d idle=%0d expected 6 9 10", s1, s4, sb);
        end
        n_chk++;
        if ({overrun, dout} !== {1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL overrun_sticky: got ovr=%b dout=%h expected 1 5a", overrun, dout);
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL overrun_model: got %0d differing cycles expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        cyc(0, 1, 0, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h81);
        cyc(1, 1, 1, 1, 8'h77);
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1, 1, 0, 0, 8'h00);
            if (update_op_II) found = 1;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL rstmid_reach: got no S1 within 40 cycles expected S1");
        end
        cyc(0, 1, 0, 0, 8'h00);
        n_chk++;
        if ({slot, dout, busy, update_op_II, update_op_IV, zero} !== {5'd0, 8'h00, 4'b0001}) begin
            n_fail++;
            $display("FAIL rstmid_clear: got slot=%0d dout=%h busy=%b II=%b IV=%b expected 0 00 0 0 0",
                     slot, dout, busy, update_op_II, update_op_IV);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 0, 8'h00);
            n_chk++;
            if (update_op_IV !== 1'b0 || obs() !== expv()) begin
                n_fail++;
                $display("FAIL rstmid_after: got %h expected %h", obs(), expv());
            end
        end
    endtask

    task automatic test_cen_hold();
        int s1, s2, s4, sb, bad;
        logic z2;
        cyc(0, 1, 0, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'hE4);
        cyc(1, 1, 1, 1, 8'h99);
        cyc(1, 1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 1, i[0], 8'($urandom));
            n_chk++;
            if ({slot, busy, update_op_I, up_wav, dout, overrun} !== {5'd3, 3'b101, 8'h99, 1'b0}) begin
                n_fail++;
                $display("FAIL cenhold_frozen: got slot=%0d busy=%b I=%b wav=%b dout=%h ovr=%b expected 3 1 0 1 99 0",
                         slot, busy, update_op_I, up_wav, dout, overrun);
            end
        end
        cyc(1, 1, 0, 0, 8'h00);
        n_chk++;
        if ({slot, update_op_I} !== {5'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL cenhold_resume: got slot=%0d I=%b expected 4 1", slot, update_op_I);
        end
        watch(s1, s2, s4, sb, z2, bad);
        n_chk++;
        if ({s2, s4, sb} !== {32'sd5, 32'sd7, 32'sd8}) begin
            n_fail++;
            $display("FAIL cenhold_slots: got II=%0d IV=%0d idle=%0d expected 5 7 8", s2, s4, sb);
        end
    endtask

    task automatic test_random();
        logic r, c, w, a;
        logic [7:0] d;
        int idx;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) != 0);
            c = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 2) == 0);
            a = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if (!a && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, 4);
                d = {3'((idx == 4) ? 7 : idx + 1), 2'($urandom_range(0, 2)),
                     3'($urandom_range(0, 5))};
            end
            cyc(r, c, w, a, d);
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h expected %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_wrap();
        test_invalid();
        test_overrun();
        test_reset_mid();
        test_cen_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jtopl_slot_wr.md
JTOPL_SLOT_WR -- requirements
Module: jtopl_slot_wr

Interface
REQ-001 The block SHALL have parameter SLOTS, default 18, giving the number of operator slots per rotation.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port cen, input, 1 bit: clock enable; all state advances only on clk edges with cen=1.
REQ-005 The block SHALL have port wr, input, 1 bit: CPU write strobe, sampled on cen edges.
REQ-006 The block SHALL have port addr, input, 1 bit: 0 selects the register-address write, 1 selects the data write.
REQ-007 The block SHALL have port din, input, 8 bits: CPU write data.
REQ-008 The block SHALL have port dout, output, 8 bits: latched data, presented to the circular shift register as its din.
REQ-009 The block SHALL have ports up_mult, up_ksl_tl, up_ar_dr, up_sl_rr and up_wav, output, 1 bit each: register-group select strobes.
REQ-010 The block SHALL have ports update_op_I, update_op_II and update_op_IV, output, 1 bit each: slot-alignment strobes.
REQ-011 The block SHALL have port slot, output, 5 bits: current slot counter value.
REQ-012 The block SHALL have port zero, output, 1 bit: high while slot==0.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a write is pending.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky flag for a dropped data write.

Function
REQ-015 slot SHALL increment by 1 on every cen edge and wrap from SLOTS-1 to 0.
REQ-016 A wr with addr=0 SHALL latch din into an 8-bit selection register in any state, without disturbing a pending write.
REQ-017 A wr with addr=1 while idle SHALL decode the selection register: upper 3 bits select the group (1=mult, 2=ksl_tl, 3=ar_dr, 4=sl_rr, 7=wav); lower 5 bits are the offset.
REQ-018 Valid offsets SHALL be 0x00-0x05, 0x08-0x0D and 0x10-0x15; the target slot is (offset[4:3]*6 + offset[2:0]), giving a range of 0..17.
REQ-019 A data write with an invalid offset or an invalid group SHALL be ignored: no state change and no flag.
REQ-020 A valid data write SHALL latch din into dout, latch the target slot and group, and move the FSM from IDLE to WAIT.
REQ-021 The FSM states SHALL be IDLE, WAIT, S1, S2, S3.
REQ-022 In WAIT, on the cen edge where slot==target, the FSM SHALL go to S1; S1 SHALL go to S2, S2 to S3, and S3 to IDLE, each on the next cen edge.
REQ-023 update_op_I SHALL equal (state==WAIT && slot==target).
REQ-024 update_op_II SHALL equal (state==S1).
REQ-025 update_op_IV SHALL equal (state==S3).
REQ-026 The up_* output matching the latched group SHALL be high in states WAIT through S3; the others SHALL be 0.
REQ-027 busy SHALL equal (state!=IDLE).
REQ-028 Worst-case latency from the data-write cen edge to update_op_I SHALL be SLOTS cen periods; the return to IDLE SHALL follow 3 cen periods after update_op_I.
REQ-029 If the target equals slot at the write edge, update_op_I SHALL occur one full rotation later (slot is already advancing).
REQ-030 A data write while busy SHALL be dropped and SHALL set overrun; overrun SHALL clear only on reset.
REQ-031 When the target is 16 or 17, update_op_II and update_op_IV SHALL follow slot wrap-around with no special case.
REQ-032 With cen=0, all outputs SHALL hold their values, and wr SHALL be ignored.
REQ-033 dout SHALL hold its value until the next accepted data write.

Reset
REQ-034 On a clk edge with rst_n=0 (cen irrelevant), the block SHALL clear: slot=0, state=IDLE, selection register=0, dout=0, target=0, overrun=0.
REQ-035 During and after reset, all strobes SHALL be 0, busy SHALL be 0, and zero SHALL be 1.
REQ-036 Reset asserted mid-operation (WAIT..S3) SHALL abort the pending write, with no strobe in the following cycle.

Verification
REQ-037 Bench: slot=0, write addr 0x20, then data 0xA5 -> up_mult high, dout=0xA5, update_op_I when slot=0 (next rotation), II at slot=1, IV at slot=3, busy clears at slot=4.
REQ-038 Bench: addr 0x55, data 0x3F -> target=17, update_op_I at slot 17, II at slot 0, IV at slot 2; zero asserts during S1.
REQ-039 Bench: addr 0x26 (offset 6) or 0xA0, data 0x11 -> no busy, no strobes, dout unchanged, overrun=0.
REQ-040 Bench: a second data write while busy -> dropped, overrun=1, the original dout and target are completed unchanged.
REQ-041 Bench: rst_n=0 for one cen while in S1 -> state IDLE, no update_op_IV, slot=0, dout=0.
REQ-042 Bench: cen held at 0 for 5 clk cycles mid-WAIT -> slot and strobes frozen, and the sequence resumes exactly when cen returns.
